ntt_intt_ctrl: RTL and testbench
================================

NTT_INTT_CTRL -- requirements
Module: ntt_intt_ctrl

Interface
REQ-001 Parameter N, default 17, meaning coefficient width in bits.
REQ-002 Parameter D, default 16, meaning coefficients per vector.
REQ-003 Parameter LAT, default 16, meaning PU compute cycles per job (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_valid  input  1  job offered.
REQ-007 s_ready  output  1  controller accepts a job.
REQ-008 s_data  input  D*N  input coefficients, coefficient k at bits [N*(k+1)-1:N*k].
REQ-009 s_inv  input  1  job direction (0 = forward NTT, 1 = inverse).
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 pu_a  output  D*N  operand vector to the ntt_intt_pu a port.
REQ-012 pu_inv  output  1  direction to the ntt_intt_pu inv port.
REQ-013 pu_rst  output  1  active-high clear to the ntt_intt_pu rst port.
REQ-014 pu_an  input  D*N  result vector from the ntt_intt_pu an port.
REQ-015 m_valid  output  1  result available.
REQ-016 m_ready  input  1  consumer accepts the result.
REQ-017 m_data  output  D*N  captured result.
REQ-018 m_inv  output  1  direction of the job that produced m_data.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, CLEAR, RUN and HOLD.
REQ-021 s_ready SHALL equal (state==IDLE); a job is accepted on an edge where s_valid&&s_ready.
REQ-022 On accept, the FSM SHALL register s_data into pu_a and s_inv into pu_inv, then go IDLE->CLEAR.
REQ-023 pu_a and pu_inv SHALL stay constant from accept until the next accept.
REQ-024 In CLEAR, pu_rst SHALL be 1 for exactly one cycle; the next edge SHALL go CLEAR->RUN with cnt=0.
REQ-025 In RUN, pu_rst SHALL be 0 and cnt SHALL increment each edge; cnt width is 8 bits.
REQ-026 On the RUN edge where cnt==LAT-1, the FSM SHALL capture pu_an into m_data and pu_inv into m_inv, set m_valid=1 and go RUN->HOLD.
REQ-027 m_valid SHALL therefore rise LAT+2 edges after the accept edge (18 with defaults).
REQ-028 In HOLD, m_valid, m_data and m_inv SHALL stay stable until m_valid&&m_ready; on that edge m_valid->0 and the FSM goes HOLD->IDLE.
REQ-029 m_valid is never 1 outside HOLD; there is no back-to-back accept in HOLD, so s_ready is 0 there.
REQ-030 abort=1 on any edge SHALL force state->IDLE, m_valid->0 and pu_rst->1 for that following cycle, and SHALL discard any job in flight; abort has priority over all other transitions including accept and the m_ready handshake.
REQ-031 abort in IDLE SHALL hold s_ready at 0 for that edge (no accept) and SHALL otherwise be a no-op.
REQ-032 m_data SHALL keep its last captured value after handshake or abort; only a new capture overwrites it.
REQ-033 s_data and s_valid outside IDLE SHALL be ignored.

Reset
REQ-034 While rst=1: state=IDLE, cnt=0, pu_a=0, pu_inv=0, pu_rst=1, m_valid=0, m_data=0, m_inv=0, busy=0, and s_ready=0.
REQ-035 On the first edge after rst falls, pu_rst SHALL be 0 and s_ready SHALL be 1.
REQ-036 rst asserted mid-job SHALL clear the state immediately (asynchronously); no stale m_valid is allowed after release.

Verification
REQ-037 Reset: rst=1 mid-RUN with cnt=7 -> all outputs take the REQ-034 values without a clock edge, and s_ready=1 one edge after release.
REQ-038 Single job: s_data with coefficient 0=1 and all others 0, s_inv=0, m_ready=1 -> pu_rst is high for 1 cycle, m_valid rises 18 edges after accept, m_data equals the reference-model NTT (mod 65537), and m_valid is high 1 cycle.
REQ-039 Backpressure: m_ready=0 for 5 cycles after m_valid -> m_data/m_inv are stable, s_ready=0 and busy=1 throughout, and the FSM returns to IDLE on the handshake edge.
REQ-040 Forward then inverse: a job with s_inv=0, then its result with s_inv=1 -> the second m_data equals the original vector, m_inv=1.
REQ-041 Abort: abort at RUN cnt=3 -> IDLE next edge, m_valid never rises, pu_rst=1 one cycle; then a new job completes normally in 18 edges.
REQ-042 Ignored inputs: s_valid=1 held throughout a job -> exactly one accept per IDLE visit, and pu_a does not change during RUN/HOLD.

Source files
------------

// File: rtl/ntt_intt_ctrl.sv
// Job controller for an external ntt_intt_pu: latches one operand vector, pulses the PU
// clear for one cycle, waits LAT compute cycles, then holds the captured result until taken.
module ntt_intt_ctrl #(
    parameter int N   = 17,
    parameter int D   = 16,
    parameter int LAT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [D*N-1:0] s_data,
    input  logic           s_inv,
    input  logic           abort,
    output logic [D*N-1:0] pu_a,
    output logic           pu_inv,
    output logic           pu_rst,
    input  logic [D*N-1:0] pu_an,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [D*N-1:0] m_data,
    output logic           m_inv,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

    localparam logic [7:0] LAST = 8'(LAT - 1);

    state_t         state_q;
    logic [7:0]     cnt_q;
    logic [D*N-1:0] pu_a_q;
    logic           pu_inv_q;
    logic           pu_rst_q;
    logic           m_valid_q;
    logic [D*N-1:0] m_data_q;
    logic           m_inv_q;

    // rst and abort both block acceptance combinationally, so no job slips in on those edges.
    assign s_ready = (state_q == IDLE) && !rst && !abort;
    assign busy    = (state_q != IDLE);
    assign pu_a    = pu_a_q;
    assign pu_inv  = pu_inv_q;
    assign pu_rst  = pu_rst_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_inv   = m_inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pu_a_q    <= '0;
            pu_inv_q  <= 1'b0;
            pu_rst_q  <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_inv_q   <= 1'b0;
        end else begin
            pu_rst_q <= 1'b0;
            if (abort) begin
                // m_data/m_inv and the PU operands are deliberately left as they are.
                state_q   <= IDLE;
                m_valid_q <= 1'b0;
                pu_rst_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (s_valid && s_ready) begin
                            pu_a_q   <= s_data;
                            pu_inv_q <= s_inv;
                            pu_rst_q <= 1'b1;
                            state_q  <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST) begin
                            m_data_q  <= pu_an;
                            m_inv_q   <= pu_inv_q;
                            m_valid_q <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ntt_intt_ctrl.sv
// Bench for ntt_intt_ctrl: a latency-accurate PU stand-in, random jobs scored against a
// direct-sum NTT/INTT over Z_65537, plus reset, backpressure and abort scenarios.
module tb_ntt_intt_ctrl;
    localparam int    N   = 17;
    localparam int    D   = 16;
    localparam int    LAT = 16;
    localparam int    W   = N * D;
    localparam longint P  = 65537;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_inv = 1'b0;
    logic         abort = 1'b0;
    logic         m_ready = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_ready, pu_inv, pu_rst, m_valid, m_inv, busy;
    logic [W-1:0] pu_a, pu_an, m_data;

    ntt_intt_ctrl #(.N(N), .D(D), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_inv(s_inv), .abort(abort), .pu_a(pu_a), .pu_inv(pu_inv), .pu_rst(pu_rst),
        .pu_an(pu_an), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_inv(m_inv), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int accepts = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         inv;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    function automatic longint modpow(input longint b, input longint e);
        longint r, bb, ee;
        r = 1; bb = b % P; ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % P;
            bb = (bb * bb) % P;
            ee = ee >> 1;
        end
        return r;
    endfunction

    // Textbook transform: X[k] = sum_j a[j]*w^(jk); inverse uses w^-1 and scales by 1/D.
    function automatic logic [W-1:0] xform(input logic [W-1:0] a, input logic inv);
        longint w, s, scale, c;
        logic [W-1:0] r;
        w = modpow(3, (P - 1) / D);
        if (inv) w = modpow(w, P - 2);
        scale = inv ? modpow(longint'(D), P - 2) : 1;
        r = '0;
        for (int k = 0; k < D; k++) begin
            s = 0;
            for (int j = 0; j < D; j++) begin
                c = longint'(a[N*j +: N]);
                s = (s + c * modpow(w, longint'((j * k) % D))) % P;
            end
            s = (s * scale) % P;
            r[N*k +: N] = s[N-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        int t;
        for (int k = 0; k < D; k++) begin
            t = int'($urandom_range(0, 65536));
            v[N*k +: N] = t[N-1:0];
        end
        return v;
    endfunction

    // PU stand-in: result only becomes correct LAT-1 edges after its clear is released.
    logic [7:0]   stub_cnt;
    logic [W-1:0] good;
    always @(posedge clk) begin
        if (pu_rst) stub_cnt <= 8'd0;
        else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
    end
    assign good  = xform(pu_a, pu_inv);
    assign pu_an = (stub_cnt >= 8'(LAT - 1)) ? good : ~good;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: results are scored whenever a handshake (not overridden by abort) is pending.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_valid && s_ready) accepts++;
            if (m_valid && m_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h expected none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chkv("m_data", m_data, mon_e.data);
                    chk("m_inv", 64'(m_inv), 64'(mon_e.inv));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic inv);
        exp_t e;
        e.data = d;
        e.inv  = inv;
        exp_q.push_back(e);
    endtask

    task automatic accept_job(input logic [W-1:0] d, input logic inv, input bit hold_valid);
        chk("s_ready_before_accept", 64'(s_ready), 64'(1));
        s_valid = 1'b1;
        s_data  = d;
        s_inv   = inv;
        tick();
        if (!hold_valid) s_valid = 1'b0;
        chk("pu_rst_after_accept", 64'(pu_rst), 64'(1));
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("s_ready_after_accept", 64'(s_ready), 64'(0));
        chkv("pu_a_latched", pu_a, d);
        chk("pu_inv_latched", 64'(pu_inv), 64'(inv));
    endtask

    // The result must appear on the (LAT+1)-th edge after the accept edge, i.e. the
    // (LAT+2)-th edge counting the accept edge itself.
    task automatic wait_result(input logic [W-1:0] d, input logic inv, input bit jitter);
        int  lat = -1;
        bit  bad = 1'b0;
        for (int k = 1; k <= LAT + 10; k++) begin
            if (jitter) s_data = rand_vec();
            tick();
            if (k == 1) chk("pu_rst_one_cycle", 64'(pu_rst), 64'(0));
            if (pu_a !== d || pu_inv !== inv || pu_rst !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            if (m_valid) begin
                lat = k;
                break;
            end
        end
        chk("result_latency", 64'(lat), 64'(LAT + 1));
        chk("operands_stable", 64'(bad), 64'(0));
    endtask

    task automatic run_job(input logic [W-1:0] d, input logic inv,
                           input logic [W-1:0] exp_d, input int bp);
        logic [W-1:0] md;
        logic         mi;
        bit           bad;
        m_ready = (bp == 0);
        push_exp(exp_d, inv);
        accept_job(d, inv, 1'b0);
        wait_result(d, inv, 1'b0);
        if (bp > 0) begin
            md  = m_data;
            mi  = m_inv;
            bad = 1'b0;
            for (int i = 0; i < bp; i++) begin
                tick();
                if (m_data !== md || m_inv !== mi || m_valid !== 1'b1 ||
                    s_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            end
            chk("backpressure_hold", 64'(bad), 64'(0));
            m_ready = 1'b1;
        end
        tick();
        chk("m_valid_after_handshake", 64'(m_valid), 64'(0));
        chk("idle_after_handshake", 64'(busy), 64'(0));
        chk("s_ready_after_handshake", 64'(s_ready), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v, f, ones, last_md;
        logic         inv;
        bit           bad;
        int           acc0;

        // Reset state
        tick();
        tick();
        chk("rst_pu_rst", 64'(pu_rst), 64'(1));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chkv("rst_m_data", m_data, '0);
        chkv("rst_pu_a", pu_a, '0);
        rst = 1'b0;
        tick();
        chk("release_s_ready", 64'(s_ready), 64'(1));
        chk("release_pu_rst", 64'(pu_rst), 64'(0));

        // Impulse: forward transform of a delta is all ones
        v = '0;
        v[0 +: N] = 17'd1;
        ones = '0;
        for (int k = 0; k < D; k++) ones[N*k +: N] = 17'd1;
        run_job(v, 1'b0, ones, 0);

        // Forward then inverse returns the original vector
        v = rand_vec();
        f = xform(v, 1'b0);
        run_job(v, 1'b0, f, 0);
        run_job(f, 1'b1, v, 0);

        // Backpressure
        v = rand_vec();
        run_job(v, 1'b1, xform(v, 1'b1), 5);

        // Random jobs
        for (int i = 0; i < 6; i++) begin
            v   = rand_vec();
            inv = 1'($urandom_range(0, 1));
            run_job(v, inv, xform(v, inv), int'($urandom_range(0, 3)));
        end
        last_md = xform(v, inv);

        // Abort in RUN at cnt=3
        m_ready = 1'b1;
        accept_job(rand_vec(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_busy", 64'(busy), 64'(0));
        chk("abort_run_pu_rst", 64'(pu_rst), 64'(1));
        chk("abort_run_m_valid", 64'(m_valid), 64'(0));
        chkv("abort_run_m_data_kept", m_data, last_md);
        bad = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (m_valid !== 1'b0 || busy !== 1'b0 || pu_rst !== 1'b0) bad = 1'b1;
        end
        chk("abort_run_quiet", 64'(bad), 64'(0));
        v = rand_vec();
        run_job(v, 1'b0, xform(v, 1'b0), 0);

        // Abort in HOLD beats the handshake; captured result is retained
        v = rand_vec();
        m_ready = 1'b0;
        accept_job(v, 1'b1, 1'b0);
        wait_result(v, 1'b1, 1'b0);
        m_ready = 1'b1;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_hold_m_valid", 64'(m_valid), 64'(0));
        chk("abort_hold_busy", 64'(busy), 64'(0));
        chk("abort_hold_pu_rst", 64'(pu_rst), 64'(1));
        chkv("abort_hold_m_data_kept", m_data, xform(v, 1'b1));
        chk("abort_hold_m_inv_kept", 64'(m_inv), 64'(1));

        // Abort in IDLE blocks acceptance
        tick();
        acc0    = accepts;
        s_valid = 1'b1;
        s_data  = rand_vec();
        abort   = 1'b1;
        #1;
        chk("abort_idle_s_ready", 64'(s_ready), 64'(0));
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort_idle_no_accept", 64'(busy), 64'(0));
        chk("abort_idle_accepts", 64'(accepts - acc0), 64'(0));

        // s_valid held and s_data churning throughout a job
        tick();
        acc0 = accepts;
        v    = rand_vec();
        m_ready = 1'b1;
        push_exp(xform(v, 1'b0), 1'b0);
        accept_job(v, 1'b0, 1'b1);
        wait_result(v, 1'b0, 1'b1);
        tick();
        s_valid = 1'b0;
        chk("held_valid_idle", 64'(busy), 64'(0));
        chk("held_valid_one_accept", 64'(accepts - acc0), 64'(1));

        // Asynchronous reset mid-RUN at cnt=7
        tick();
        accept_job(rand_vec(), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pu_rst", 64'(pu_rst), 64'(1));
        chk("async_rst_s_ready", 64'(s_ready), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_m_valid", 64'(m_valid), 64'(0));
        chk("async_rst_m_inv", 64'(m_inv), 64'(0));
        chk("async_rst_pu_inv", 64'(pu_inv), 64'(0));
        chkv("async_rst_m_data", m_data, '0);
        chkv("async_rst_pu_a", pu_a, '0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));
        chk("post_rst_pu_rst", 64'(pu_rst), 64'(0));
        chk("post_rst_m_valid", 64'(m_valid), 64'(0));
        v = rand_vec();
        run_job(v, 1'b1, xform(v, 1'b1), 2);

        tick();
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
